// File: rtl/waterfall_scroller_if.sv
// Memory-side bus of the waterfall scroller: freq-bin BRAM read port and
// single-port frame-buffer RAM port. The controller is the master.
interface waterfall_scroller_if #(
  parameter int PIX_W     = 8,
  parameter int FB_ADDR_W = 17
) ();
  logic [8:0]           bin_addr;
  logic                 bin_ren;
  logic [PIX_W-1:0]     bin_rdata;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]     fb_wdata;
  logic                 fb_wen;

  modport master (
    output bin_addr, bin_ren, fb_addr, fb_wdata, fb_wen,
    input  bin_rdata
  );

  modport slave (
    input  bin_addr, bin_ren, fb_addr, fb_wdata, fb_wen,
    output bin_rdata
  );
endinterface

// File: rtl/waterfall_scroller.sv
// Scrolling waterfall frame-buffer controller.
// Active video: frame-buffer read addresses with a circular row offset.
// Lower blanking: one new row of gain-scaled bins is written, at a
// programmable frame rate, unless frozen. Clears are queued to blanking.
module waterfall_scroller #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240,
  parameter int PIX_W     = 8,
  parameter int BINS      = 320,
  parameter int FB_ADDR_W = 17,
  parameter int DIV_W     = 4
) (
  input  logic             pixclk,
  input  logic             resetn,
  input  logic [8:0]       x,
  input  logic [7:0]       y,
  input  logic             lower_blank,
  input  logic [DIV_W-1:0] scroll_div,
  input  logic [2:0]       gain,
  input  logic             freeze,
  input  logic             clear_req,
  waterfall_scroller_if.master mem,
  output logic             busy,
  output logic             row_done,
  output logic             overrun
);

  // Column counter covers H_VISIBLE bin reads plus one trailing write plus the exit cycle.
  localparam int CW = $clog2(H_VISIBLE + 2);
  localparam logic [CW-1:0]        H_CW    = CW'(H_VISIBLE);
  localparam logic [CW-1:0]        LAST_CW = CW'(H_VISIBLE + 1);
  localparam logic [CW-1:0]        BINS_CW = CW'(BINS);
  localparam logic [FB_ADDR_W-1:0] H_FB    = FB_ADDR_W'(H_VISIBLE);
  localparam logic [FB_ADDR_W-1:0] V_FB    = FB_ADDR_W'(V_VISIBLE);
  // One extra bit so the end-of-clear compare never aliases at a power-of-two buffer size.
  localparam logic [FB_ADDR_W:0]   TOTAL   = (FB_ADDR_W + 1)'(H_VISIBLE * V_VISIBLE);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_VIDEO = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t               state_r;
  logic [FB_ADDR_W:0]   clr_cnt_r;
  logic [CW-1:0]        wr_cnt_r;
  logic [FB_ADDR_W-1:0] y_offset_r;
  logic [DIV_W-1:0]     frame_cnt_r;
  logic                 clear_pend_r;
  logic                 lb_prev_r;
  logic                 overrun_r;
  logic                 busy_r;
  logic                 row_done_r;
  logic [FB_ADDR_W-1:0] fb_addr_r;
  logic                 fb_wen_r;
  logic                 wr_valid_r;
  logic [8:0]           bin_addr_r;
  logic                 bin_ren_r;

  logic [FB_ADDR_W-1:0] row_sum_s;
  logic [FB_ADDR_W-1:0] row_s;
  logic [FB_ADDR_W-1:0] video_addr_s;
  logic [FB_ADDR_W-1:0] wr_base_s;
  logic [PIX_W-1:0]     fb_wdata_s;

  // Left shift by gain, saturating; overflow is seen in the 7 bits above PIX_W.
  function automatic logic [PIX_W-1:0] sat_shift(input logic [PIX_W-1:0] d,
                                                 input logic [2:0] sh);
    logic [PIX_W+6:0] w;
    w = {7'd0, d} << sh;
    if (|w[PIX_W+6:PIX_W]) begin
      sat_shift = {PIX_W{1'b1}};
    end else begin
      sat_shift = w[PIX_W-1:0];
    end
  endfunction

  // Display address with circular row wrap, and base of the row being written.
  always_comb begin
    row_sum_s = FB_ADDR_W'(y) + y_offset_r;
    if (row_sum_s >= V_FB) begin
      row_s = row_sum_s - V_FB;
    end else begin
      row_s = row_sum_s;
    end
    video_addr_s = FB_ADDR_W'(x) + row_s * H_FB;
    wr_base_s    = y_offset_r * H_FB;
  end

  // Write data follows the BRAM output in the cycle it becomes valid; columns past BINS are 0.
  always_comb begin
    if (wr_valid_r) begin
      fb_wdata_s = sat_shift(mem.bin_rdata, gain);
    end else begin
      fb_wdata_s = {PIX_W{1'b0}};
    end
  end

  // Controller FSM with registered memory-side and status outputs.
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_CLEAR;
      clr_cnt_r    <= '0;
      wr_cnt_r     <= '0;
      y_offset_r   <= '0;
      frame_cnt_r  <= '0;
      clear_pend_r <= 1'b0;
      lb_prev_r    <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b1;
      row_done_r   <= 1'b0;
      fb_addr_r    <= '0;
      fb_wen_r     <= 1'b0;
      wr_valid_r   <= 1'b0;
      bin_addr_r   <= 9'd0;
      bin_ren_r    <= 1'b0;
    end else begin
      lb_prev_r  <= lower_blank;
      row_done_r <= 1'b0;
      fb_wen_r   <= 1'b0;
      wr_valid_r <= 1'b0;
      bin_ren_r  <= 1'b0;
      bin_addr_r <= 9'd0;
      if (clear_req) begin
        clear_pend_r <= 1'b1;
      end
      // Blanking ended while a long operation was still running.
      if (lb_prev_r && !lower_blank && (state_r == ST_CLEAR || state_r == ST_WRITE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == TOTAL) begin
            state_r      <= ST_VIDEO;
            busy_r       <= 1'b0;
            clr_cnt_r    <= '0;
            y_offset_r   <= '0;
            frame_cnt_r  <= '0;
            clear_pend_r <= 1'b0;
          end else begin
            fb_wen_r  <= 1'b1;
            fb_addr_r <= clr_cnt_r[FB_ADDR_W-1:0];
            clr_cnt_r <= clr_cnt_r + 1'b1;
          end
        end
        ST_VIDEO: begin
          fb_addr_r <= video_addr_s;
          if (lower_blank) begin
            if (clear_pend_r) begin
              state_r   <= ST_CLEAR;
              busy_r    <= 1'b1;
              clr_cnt_r <= '0;
            end else if (!freeze && frame_cnt_r == scroll_div) begin
              state_r     <= ST_WRITE;
              busy_r      <= 1'b1;
              frame_cnt_r <= '0;
              wr_cnt_r    <= '0;
            end else begin
              state_r <= ST_WAIT;
              if (!freeze) begin
                // A divider lowered below the running count restarts the count.
                frame_cnt_r <= (frame_cnt_r > scroll_div) ? '0 : frame_cnt_r + DIV_W'(1);
              end
            end
          end
        end
        ST_WRITE: begin
          // Step k reads bin k and writes column k-1 from the data read a cycle earlier.
          if (wr_cnt_r < H_CW) begin
            bin_ren_r  <= 1'b1;
            bin_addr_r <= 9'(wr_cnt_r);
          end
          if (wr_cnt_r != '0 && wr_cnt_r <= H_CW) begin
            fb_wen_r   <= 1'b1;
            fb_addr_r  <= wr_base_s + FB_ADDR_W'(wr_cnt_r - CW'(1));
            wr_valid_r <= (wr_cnt_r <= BINS_CW);
          end
          if (wr_cnt_r == LAST_CW) begin
            state_r    <= ST_WAIT;
            busy_r     <= 1'b0;
            row_done_r <= 1'b1;
            wr_cnt_r   <= '0;
            y_offset_r <= (y_offset_r == V_FB - FB_ADDR_W'(1)) ? '0 : y_offset_r + FB_ADDR_W'(1);
          end else begin
            wr_cnt_r <= wr_cnt_r + CW'(1);
          end
        end
        ST_WAIT: begin
          if (!lower_blank) begin
            state_r <= ST_VIDEO;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign mem.bin_addr = bin_addr_r;
  assign mem.bin_ren  = bin_ren_r;
  assign mem.fb_addr  = fb_addr_r;
  assign mem.fb_wen   = fb_wen_r;
  assign mem.fb_wdata = fb_wdata_s;
  assign busy         = busy_r;
  assign row_done     = row_done_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_waterfall_scroller.sv
// Bench for waterfall_scroller: small 8x4 buffer, scoreboard of expected
// frame-buffer writes checked whenever the DUT asserts fb_wen.
module tb_waterfall_scroller;
  localparam int H = 8;
  localparam int V = 4;
  localparam int BINS = 6;
  localparam int PW = 8;
  localparam int AW = 8;
  localparam int DW = 4;

  logic          pixclk = 1'b0;
  logic          resetn;
  logic [8:0]    x;
  logic [7:0]    y;
  logic          lower_blank;
  logic [DW-1:0] scroll_div;
  logic [2:0]    gain;
  logic          freeze;
  logic          clear_req;
  logic          busy;
  logic          row_done;
  logic          overrun;

  waterfall_scroller_if #(.PIX_W(PW), .FB_ADDR_W(AW)) bus ();

  waterfall_scroller #(
    .H_VISIBLE(H), .V_VISIBLE(V), .PIX_W(PW), .BINS(BINS), .FB_ADDR_W(AW), .DIV_W(DW)
  ) dut (
    .pixclk(pixclk), .resetn(resetn), .x(x), .y(y), .lower_blank(lower_blank),
    .scroll_div(scroll_div), .gain(gain), .freeze(freeze), .clear_req(clear_req),
    .mem(bus.master), .busy(busy), .row_done(row_done), .overrun(overrun)
  );

  always #5 pixclk = ~pixclk;

  typedef struct { int addr; int data; } exp_t;
  exp_t exp_q[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  rd_cnt   = 0;
  bit  sb_en    = 1'b0;
  int  bram_mode = 0;    // 0: data = addr+1, 1: constant
  int  bram_const = 0;

  // Reference state of the controller.
  int  m_yoff = 0;
  int  m_cnt  = 0;
  bit  m_pend = 1'b0;
  int  m_rows = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int bram_val(input int a);
    return (bram_mode == 0) ? a + 1 : bram_const;
  endfunction

  function automatic int sat_ref(input int v, input int g);
    int t;
    t = v << g;
    return (t > 255) ? 255 : t;
  endfunction

  // Freq-bin BRAM: registered read, data valid the cycle after the address.
  always @(posedge pixclk) begin
    if (bus.bin_ren) bus.bin_rdata <= PW'(bram_val(int'(bus.bin_addr)));
  end

  // Scoreboard monitor: every frame-buffer write must match the next expected entry.
  always @(negedge pixclk) begin
    if (row_done) rd_cnt++;
    if (sb_en && bus.fb_wen) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_write", 32'(bus.fb_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_value("wr_addr", 32'(bus.fb_addr), 32'(e.addr));
        check_value("wr_data", 32'(bus.fb_wdata), 32'(e.data));
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < H * V; i++) exp_q.push_back('{addr: i, data: 0});
  endtask

  task automatic push_row();
    for (int c = 0; c < H; c++)
      exp_q.push_back('{addr: m_yoff * H + c, data: (c < BINS) ? sat_ref(bram_val(c), int'(gain)) : 0});
    m_yoff = (m_yoff == V - 1) ? 0 : m_yoff + 1;
    m_rows++;
  endtask

  task automatic decide();
    if (!freeze && m_cnt == int'(scroll_div)) begin
      m_cnt = 0;
      push_row();
    end else if (!freeze) begin
      m_cnt = (m_cnt > int'(scroll_div)) ? 0 : m_cnt + 1;
    end
  endtask

  // One blanking interval held for 'hold' cycles; optional clear_req pulse 3 cycles in.
  task automatic do_blank(input int hold, input bit clr_mid);
    rd_cnt = 0;
    m_rows = 0;
    if (m_pend) begin
      push_clear();
      m_yoff = 0; m_cnt = 0; m_pend = 1'b0;
      // Blanking is still high after the clear, so the frame counter is evaluated again.
      if (hold > 40) decide();
    end else begin
      decide();
    end
    @(negedge pixclk);
    lower_blank = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge pixclk);
      clear_req = (clr_mid && i == 3);
    end
    clear_req = 1'b0;
    if (clr_mid) m_pend = 1'b1;
    lower_blank = 1'b0;
    repeat (20) @(negedge pixclk);
    check_value("sb_empty", 32'(exp_q.size()), 32'd0);
    check_value("row_done_cnt", 32'(rd_cnt), 32'(m_rows));
  endtask

  task automatic check_video(input int xi, input int yi);
    @(negedge pixclk);
    x = 9'(xi);
    y = 8'(yi);
    @(negedge pixclk);
    check_value("video_addr", 32'(bus.fb_addr), 32'(xi + ((yi + m_yoff) % V) * H));
    check_value("video_wen", 32'(bus.fb_wen), 32'd0);
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge pixclk);
      cyc++;
    end while (busy && cyc < limit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    resetn = 1'b0; x = '0; y = '0; lower_blank = 1'b0; scroll_div = '0;
    gain = '0; freeze = 1'b0; clear_req = 1'b0;
    repeat (3) @(negedge pixclk);
    check_value("rst_fb_wen", 32'(bus.fb_wen), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd1);
    check_value("rst_overrun", 32'(overrun), 32'd0);
    check_value("rst_bin_ren", 32'(bus.bin_ren), 32'd0);
    check_value("rst_fb_addr", 32'(bus.fb_addr), 32'd0);

    // Power-up clear: 32 zero writes then idle.
    push_clear();
    sb_en = 1'b1;
    resetn = 1'b1;
    wait_idle(200, cyc);
    check_value("clear_len", 32'(cyc), 32'(H * V + 1));
    check_value("clear_sb_empty", 32'(exp_q.size()), 32'd0);
    check_value("clear_overrun", 32'(overrun), 32'd0);

    // Basic row write, gain 0.
    do_blank(60, 1'b0);
    check_video(3, 3);
    check_video(5, 1);

    // Saturating gain.
    gain = 3'd2; bram_mode = 1; bram_const = 8'h50;
    do_blank(60, 1'b0);
    bram_const = 8'h10;
    do_blank(60, 1'b0);

    // Offset wrap over a full buffer.
    gain = 3'd0; bram_mode = 0;
    do_blank(60, 1'b0);
    for (int i = 0; i < 4; i++) do_blank(60, 1'b0);
    check_video(3, 0);
    check_video(7, 2);

    // Blanking ends during WRITE: row still completes, overrun sticks.
    check_value("pre_overrun", 32'(overrun), 32'd0);
    do_blank(3, 1'b0);
    check_value("overrun_set", 32'(overrun), 32'd1);
    do_blank(60, 1'b0);
    check_value("overrun_sticky", 32'(overrun), 32'd1);

    // Frame divider, then freeze.
    scroll_div = 4'd2;
    for (int i = 0; i < 7; i++) do_blank(60, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) do_blank(60, 1'b0);
    freeze = 1'b0;
    scroll_div = 4'd0;
    do_blank(60, 1'b0);

    // clear_req during a WRITE is serviced at the following blank.
    do_blank(60, 1'b1);
    do_blank(60, 1'b0);
    check_video(2, 1);

    // Asynchronous reset in the middle of a WRITE.
    sb_en = 1'b0;
    @(negedge pixclk);
    lower_blank = 1'b1;
    repeat (3) @(posedge pixclk);
    #2;
    check_value("wen_before_rst", 32'(bus.fb_wen), 32'd1);
    resetn = 1'b0;
    #1;
    check_value("async_rst_wen", 32'(bus.fb_wen), 32'd0);
    check_value("async_rst_busy", 32'(busy), 32'd1);
    check_value("async_rst_overrun", 32'(overrun), 32'd0);
    lower_blank = 1'b0;
    exp_q.delete();
    m_yoff = 0; m_cnt = 0; m_pend = 1'b0;
    push_clear();
    @(negedge pixclk);
    sb_en = 1'b1;
    resetn = 1'b1;
    wait_idle(200, cyc);
    check_value("reclear_len", 32'(cyc), 32'(H * V + 1));
    check_value("reclear_sb_empty", 32'(exp_q.size()), 32'd0);
    do_blank(60, 1'b0);
    check_video(4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
